atomic_counter_bank: RTL and testbench
======================================

ATOMIC_COUNTER_BANK -- requirements
Module: atomic_counter_bank

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of independent event counters (1..16).
REQ-002 Parameter CNT_W, default 64, SHALL set the counter width; CNT_W SHALL be a multiple of BUS_W, at least 2*BUS_W.
REQ-003 Parameter BUS_W, default 32, SHALL set the read-bus width; WORDS = CNT_W/BUS_W.
REQ-004 clk  in  1  SHALL be the single clock; all flops SHALL be rising-edge.
REQ-005 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 trig_i  in  NUM_CH  SHALL carry one increment request per channel per cycle.
REQ-007 req_i  in  1  SHALL be the read request; one BUS_W word is read per request cycle.
REQ-008 atomic_i  in  1  SHALL mark, when high with req_i, the first word of a snapshot read.
REQ-009 ch_sel_i  in  max(1,clog2(NUM_CH))  SHALL select the channel for atomic requests and loads.
REQ-010 load_i  in  1  SHALL request a preload of the channel selected by ch_sel_i.
REQ-011 load_val_i  in  CNT_W  SHALL carry the preload value.
REQ-012 ack_o  out  1  SHALL acknowledge each request cycle.
REQ-013 count_o  out  BUS_W  SHALL carry the returned counter word.
REQ-014 err_o  out  1  SHALL flag a protocol-error request.

Function
REQ-015 Each counter SHALL increment by 1 in every cycle its trig_i bit is high; multi-cycle trig_i SHALL increment every cycle.
REQ-016 load_i SHALL write load_val_i to the selected counter next edge, overriding that channel's trig_i in the same cycle.
REQ-017 ack_o SHALL equal req_i delayed one cycle, for every request, regardless of atomic_i or errors.
REQ-018 count_o and err_o SHALL be registered, valid in the ack_o cycle, and 0 whenever ack_o is low.
REQ-019 FSM states: IDLE, READ; index register idx in 1..WORDS-1.
REQ-020 req_i&atomic_i in any state SHALL capture the selected counter's pre-increment value into a CNT_W snapshot, return word 0 next cycle, set idx=1, and enter READ.
REQ-021 An atomic request in READ SHALL abandon the open snapshot and start a new one without error.
REQ-022 req_i&!atomic_i in READ SHALL return snapshot word idx; if idx==WORDS-1 -> IDLE, else idx+1.
REQ-023 READ SHALL hold the snapshot across cycles with req_i low; gaps between the parts of a read are legal.
REQ-024 req_i&!atomic_i in IDLE SHALL return count_o=0 with err_o=1 for that ack cycle; state unchanged.
REQ-025 ch_sel_i SHALL be ignored on non-atomic requests; the channel is fixed at the atomic request.
REQ-026 Counter increments and loads after capture SHALL NOT alter the snapshot.
REQ-027 A load on the channel being captured in the same cycle SHALL NOT affect the snapshot (pre-load value captured).
REQ-028 ch_sel_i >= NUM_CH on an atomic request SHALL return all-zero words with err_o=1 on the first word only.

Reset
REQ-029 reset_n low SHALL asynchronously clear all counters, snapshot, idx, ack_o, count_o, err_o, and force IDLE.
REQ-030 Reset mid-read SHALL discard the snapshot; the next non-atomic request SHALL be an IDLE error.

Configuration
REQ-031 Macro ATOMIC_COUNTER_SATURATE_EN defined: a counter at all-ones SHALL hold all-ones on trig_i.
REQ-032 Macro ATOMIC_COUNTER_SATURATE_EN undefined: a counter SHALL wrap from all-ones to 0.

Verification
REQ-033 Load ch1=0x0000_0000_FFFF_FFFF; trig_i[1] high continuously; atomic req then non-atomic req -> words form one consistent value, e.g. 0x0000_0000_FFFF_FFFF then 0x0000_0000, never 0x0000_0001 upper.
REQ-034 Load ch2=0x1234_5678_9ABC_DEF0; atomic req ch2, 5 idle cycles with trig_i[2] high, non-atomic req -> 0x9ABC_DEF0 then 0x1234_5678; ack_o high only in the two ack cycles.
REQ-035 Back-to-back req_i for 4 cycles, atomic_i=1,0,1,0, ch_sel_i=0 then 3 -> ack_o high 4 cycles, ch0 low/high then ch3 low/high, err_o=0.
REQ-036 Non-atomic req from IDLE -> ack_o=1, count_o=0, err_o=1 one cycle later; atomic req during READ -> restart, no error.
REQ-037 Load ch0=all-ones, trig_i[0] pulse, read -> 0x0 (wrap) without ATOMIC_COUNTER_SATURATE_EN, all-ones with it.
REQ-038 reset_n low between atomic and non-atomic request -> outputs 0 asynchronously; following non-atomic request -> err_o=1, count_o=0.

Source files
------------

// File: rtl/atomic_counter_bank.sv
// Bank of NUM_CH event counters with a multi-word atomic snapshot read port.
// Define ATOMIC_COUNTER_SATURATE_EN to make counters stick at all-ones instead of wrapping.
module atomic_counter_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 64,
    parameter int BUS_W  = 32,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] trig_i,
    input  logic              req_i,
    input  logic              atomic_i,
    input  logic [SEL_W-1:0]  ch_sel_i,
    input  logic              load_i,
    input  logic [CNT_W-1:0]  load_val_i,
    output logic              ack_o,
    output logic [BUS_W-1:0]  count_o,
    output logic              err_o
);

    localparam int WORDS = CNT_W / BUS_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    logic [CNT_W-1:0] r_cnt [NUM_CH];
    logic [CNT_W-1:0] w_cnt_inc [NUM_CH];
    logic [CNT_W-1:0] w_sel_cnt;
    logic             w_sel_valid;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_snap;
    logic [BUS_W-1:0] w_snap_words [WORDS];

    logic             r_ack;
    logic [BUS_W-1:0] r_count;
    logic             r_err;

    // Out-of-range selects match no channel, so they read as zero and load nothing.
    always_comb begin
        w_sel_cnt   = '0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel_i == SEL_W'(i)) begin
                w_sel_cnt   = r_cnt[i];
                w_sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef ATOMIC_COUNTER_SATURATE_EN
            w_cnt_inc[i] = (&r_cnt[i]) ? r_cnt[i] : r_cnt[i] + CNT_W'(1);
`else
            w_cnt_inc[i] = r_cnt[i] + CNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (load_i && w_sel_valid && (ch_sel_i == SEL_W'(i))) begin
                    r_cnt[i] <= load_val_i;
                end else if (trig_i[i]) begin
                    r_cnt[i] <= w_cnt_inc[i];
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < WORDS; g++) begin : g_words
            assign w_snap_words[g] = r_snap[g*BUS_W +: BUS_W];
        end
    endgenerate

    // Snapshot takes the registered (pre-increment, pre-load) counter value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_snap  <= '0;
            r_ack   <= 1'b0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_ack   <= req_i;
            r_count <= '0;
            r_err   <= 1'b0;
            if (req_i) begin
                if (atomic_i) begin
                    r_snap  <= w_sel_cnt;
                    r_count <= w_sel_cnt[BUS_W-1:0];
                    r_err   <= ~w_sel_valid;
                    r_idx   <= IDX_W'(1);
                    r_state <= ST_READ;
                end else if (r_state == ST_READ) begin
                    r_count <= w_snap_words[r_idx];
                    if (r_idx == IDX_W'(WORDS - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign ack_o   = r_ack;
    assign count_o = r_count;
    assign err_o   = r_err;

endmodule

// File: tb/tb_atomic_counter_bank.sv
// Scoreboard bench for atomic_counter_bank: stimulus pushes expected words, a negedge monitor pops them.
module tb_atomic_counter_bank;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 64;
    localparam int BUS_W  = 32;
    localparam int SEL_W  = 3;

`ifdef ATOMIC_COUNTER_SATURATE_EN
    localparam logic [31:0] SAT_LO = 32'hFFFF_FFFF;
    localparam logic [31:0] SAT_HI = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] SAT_LO = 32'h0000_0000;
    localparam logic [31:0] SAT_HI = 32'h0000_0000;
`endif

    logic              clk;
    logic              reset_n;
    logic [NUM_CH-1:0] trig_i;
    logic              req_i;
    logic              atomic_i;
    logic [SEL_W-1:0]  ch_sel_i;
    logic              load_i;
    logic [CNT_W-1:0]  load_val_i;
    logic              ack_o;
    logic [BUS_W-1:0]  count_o;
    logic              err_o;

    logic [32:0] exp_q [$];
    int          n_vec;
    int          n_err;

    atomic_counter_bank #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .BUS_W (BUS_W),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .trig_i    (trig_i),
        .req_i     (req_i),
        .atomic_i  (atomic_i),
        .ch_sel_i  (ch_sel_i),
        .load_i    (load_i),
        .load_val_i(load_val_i),
        .ack_o     (ack_o),
        .count_o   (count_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input bit atomic, input logic [SEL_W-1:0] sel,
                      input logic [31:0] exp_cnt, input bit exp_err);
        req_i    = 1'b1;
        atomic_i = atomic;
        ch_sel_i = sel;
        exp_q.push_back({exp_err, exp_cnt});
        step();
        req_i    = 1'b0;
        atomic_i = 1'b0;
    endtask

    task automatic ld(input logic [SEL_W-1:0] sel, input logic [CNT_W-1:0] val);
        load_i     = 1'b1;
        ch_sel_i   = sel;
        load_val_i = val;
        step();
        load_i     = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", {32'd0, count_o}, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("count_o", {32'd0, count_o}, {32'd0, e[31:0]});
                chk("err_o", {63'd0, err_o}, {63'd0, e[32]});
            end
        end else begin
            chk("idle_outputs", {31'd0, err_o, count_o}, 64'd0);
        end
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        trig_i     = '0;
        req_i      = 1'b0;
        atomic_i   = 1'b0;
        ch_sel_i   = '0;
        load_i     = 1'b0;
        load_val_i = '0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        chk("reset_ack", {63'd0, ack_o}, 64'd0);
        chk("reset_count", {32'd0, count_o}, 64'd0);
        chk("reset_err", {63'd0, err_o}, 64'd0);
        step();

        // counters come out of reset at zero
        rd(1'b1, 3'd0, 32'h0, 1'b0);
        rd(1'b0, 3'd0, 32'h0, 1'b0);

        // carry across the word boundary must not tear the snapshot
        trig_i[1] = 1'b1;
        ld(3'd1, 64'h0000_0000_FFFF_FFFF);
        rd(1'b1, 3'd1, 32'hFFFF_FFFF, 1'b0);
        rd(1'b0, 3'd0, 32'h0000_0000, 1'b0);
        trig_i = '0;

        // snapshot held across a gap while the counter keeps running
        ld(3'd2, 64'h1234_5678_9ABC_DEF0);
        trig_i[2] = 1'b1;
        rd(1'b1, 3'd2, 32'h9ABC_DEF0, 1'b0);
        repeat (5) step();
        rd(1'b0, 3'd0, 32'h1234_5678, 1'b0);
        trig_i = '0;

        // back-to-back reads; ch0 load in the capture cycle must not reach the snapshot
        ld(3'd0, 64'h0000_0005_0000_0007);
        ld(3'd3, 64'hAAAA_BBBB_CCCC_DDDD);
        load_i     = 1'b1;
        load_val_i = 64'h1111_2222_3333_4444;
        rd(1'b1, 3'd0, 32'h0000_0007, 1'b0);
        load_i     = 1'b0;
        rd(1'b0, 3'd3, 32'h0000_0005, 1'b0);
        rd(1'b1, 3'd3, 32'hCCCC_DDDD, 1'b0);
        rd(1'b0, 3'd0, 32'hAAAA_BBBB, 1'b0);

        // IDLE error, then restart of an open snapshot
        step();
        rd(1'b0, 3'd0, 32'h0, 1'b1);
        rd(1'b1, 3'd3, 32'hCCCC_DDDD, 1'b0);
        rd(1'b1, 3'd0, 32'h3333_4444, 1'b0);
        rd(1'b0, 3'd0, 32'h1111_2222, 1'b0);
        rd(1'b0, 3'd0, 32'h0, 1'b1);

        // invalid channel: zero words, error on the first only
        rd(1'b1, 3'd6, 32'h0, 1'b1);
        rd(1'b0, 3'd0, 32'h0, 1'b0);
        rd(1'b0, 3'd0, 32'h0, 1'b1);
        ld(3'd7, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(1'b1, 3'd0, 32'h3333_4444, 1'b0);
        rd(1'b0, 3'd0, 32'h1111_2222, 1'b0);

        // sustained trigger counts every cycle
        trig_i[4] = 1'b1;
        repeat (10) step();
        trig_i = '0;
        rd(1'b1, 3'd4, 32'd10, 1'b0);
        rd(1'b0, 3'd0, 32'd0, 1'b0);

        // all-ones plus one trigger: wrap or saturate
        ld(3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        trig_i[0] = 1'b1;
        step();
        trig_i = '0;
        rd(1'b1, 3'd0, SAT_LO, 1'b0);
        rd(1'b0, 3'd0, SAT_HI, 1'b0);

        // reset in the middle of a read, during the ack cycle
        req_i    = 1'b1;
        atomic_i = 1'b1;
        ch_sel_i = 3'd3;
        step();
        req_i    = 1'b0;
        atomic_i = 1'b0;
        chk("pre_reset_ack", {63'd0, ack_o}, 64'd1);
        chk("pre_reset_count", {32'd0, count_o}, 64'h0000_0000_CCCC_DDDD);
        #1 reset_n = 1'b0;
        #1;
        chk("async_ack", {63'd0, ack_o}, 64'd0);
        chk("async_count", {32'd0, count_o}, 64'd0);
        chk("async_err", {63'd0, err_o}, 64'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        step();
        rd(1'b0, 3'd0, 32'h0, 1'b1);
        rd(1'b1, 3'd3, 32'h0, 1'b0);
        rd(1'b0, 3'd0, 32'h0, 1'b0);

        repeat (4) step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
